// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer around a sobel_unit: issue, flush, border, tag, 2-entry output FIFO
module sobel_frame_ctrl #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int OUT_OFFSET = WIDTH + 4,
    parameter int BEAT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] u_data_in,
    output logic       u_valid_in,
    input  logic [7:0] u_data_out,
    input  logic       u_valid_out,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_last
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [BEAT_W-1:0] LAST_PIX_BEAT = BEAT_W'(WIDTH * HEIGHT - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(WIDTH * HEIGHT + OUT_OFFSET - 1);
    localparam logic [BEAT_W-1:0] FIRST_KEEP    = BEAT_W'(OUT_OFFSET + 1);
    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat;
    logic              inflight;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [7:0]        fifo_data [2];
    logic              fifo_sof  [2];
    logic              fifo_last [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_count;
    logic              credit, capture, push, pop, border, done_nxt;
    logic [7:0]        push_data;

    // At most two results may be owed to the FIFO: those stored plus the one in the unit.
    assign credit  = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && !inflight);
    assign capture = u_valid_out && inflight;
    // beat already counts the issue whose result is arriving, so it is one ahead here.
    assign push    = capture && (beat >= FIRST_KEEP);
    assign pop     = m_valid && m_ready;
    assign border  = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    assign push_data = border ? 8'd0 : u_data_out;

    assign busy    = (state == S_RUN) || (state == S_FLUSH);
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : 8'd0;
    assign m_sof   = m_valid && fifo_sof[rd_ptr];
    assign m_last  = m_valid && fifo_last[rd_ptr];

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        u_valid_in = 1'b0;
        u_data_in  = 8'd0;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                s_ready    = credit;
                u_valid_in = s_valid && credit;
                u_data_in  = s_data;
                if (s_valid && credit && beat == LAST_PIX_BEAT) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                u_valid_in = credit;
                if (credit && beat == LAST_BEAT) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (fifo_count == 2'd0 && !inflight) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            beat       <= '0;
            inflight   <= 1'b0;
            row        <= '0;
            col        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            inflight <= u_valid_in;
            if (state == S_IDLE && start) begin
                beat <= '0;
                row  <= '0;
                col  <= '0;
            end else begin
                if (u_valid_in) beat <= beat + 1'b1;
                if (push) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_sof[wr_ptr]  <= (row == '0) && (col == '0);
            fifo_last[wr_ptr] <= (row == ROW_LAST) && (col == COL_LAST);
        end
    end
endmodule
